// File: rtl/sc_fir_pkg.sv
// ============================================================================
//  Module  : sc_fir_pkg
//  Brief   : Shared constants and types for the stochastic FIR sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sc_fir_pkg;

    localparam int N      = 12;
    localparam int ORDER  = 18;
    localparam int LENGTH = ORDER + 1;
    localparam int POW2N  = 1 << N;

    // Fibonacci feedback taps for x^12 + x^11 + x^10 + x^4 + 1
    localparam logic [N-1:0] LFSR_TAPS = 12'hE08;

    typedef logic [N:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

endpackage : sc_fir_pkg

`default_nettype wire

// File: rtl/sc_lfsr.sv
// ============================================================================
//  Module  : sc_lfsr
//  Brief   : Seedable Fibonacci LFSR; advances one step per enabled cycle.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_lfsr #(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] TAPS  = 12'hE08,
    parameter logic [WIDTH-1:0] SEED  = 12'h001
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    output logic [WIDTH-1:0] state
);

    // An all-zero seed would lock the register, so it is promoted to 1.
    localparam logic [WIDTH-1:0] c_SEED = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] r_state;
    logic             w_feedback;

    assign w_feedback = ^(r_state & TAPS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_SEED;
        end else if (enable) begin
            r_state <= {r_state[WIDTH-2:0], w_feedback};
        end
    end

    assign state = r_state;

endmodule : sc_lfsr

`default_nettype wire

// File: rtl/sc_fir_sequencer.sv
// ============================================================================
//  Module  : sc_fir_sequencer
//  Brief   : Feeds taps, R_y and sel_bits to the stochastic FIR accumulator
//            for one 2^N-cycle run per sample and returns its count.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_fir_sequencer
    import sc_fir_pkg::*;
#(
    parameter logic [N-1:0] LFSR_SEED = 12'hACE
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  sample_t                sample_in,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output sample_t [LENGTH-1:0]   taps,
    output logic    [N-1:0]        R_y,
    output logic    [N-1:0]        sel_bits,
    output logic                   start,
    input  sample_t                hwa_out,
    input  logic                   hwa_done,
    output sample_t                result,
    output logic                   result_valid,
    input  logic                   result_ready
);

    localparam logic [N-1:0] c_SEL_MAX = N'(POW2N - 1);

    seq_state_t           r_state;
    seq_state_t           w_next_state;
    sample_t [LENGTH-1:0] r_taps;
    logic    [N-1:0]      r_sel;
    sample_t              r_result;
    logic                 r_result_valid;
    logic                 w_accept;
    logic                 w_lfsr_en;
    logic                 w_capture;
    logic                 w_release;
    logic                 w_hwa_done_unused;

    // Capture is keyed on the cycle index alone; the accumulator's done flag
    // carries no extra information.
    assign w_hwa_done_unused = hwa_done;

    assign w_accept = sample_valid && (r_state == IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_lfsr_en    = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (sample_valid) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_lfsr_en = 1'b1;
                if (r_sel == c_SEL_MAX) begin
                    w_capture    = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    w_release    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // sel_bits parks at its maximum outside RUN so the accumulator stays clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_taps         <= '0;
            r_sel          <= c_SEL_MAX;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_taps <= {r_taps[LENGTH-2:0], sample_in};
                r_sel  <= '0;
            end else if ((r_state == RUN) && (r_sel != c_SEL_MAX)) begin
                r_sel <= r_sel + 1'b1;
            end

            if (w_capture) begin
                r_result       <= hwa_out;
                r_result_valid <= 1'b1;
            end else if (w_release) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    sc_lfsr #(
        .WIDTH (N),
        .TAPS  (LFSR_TAPS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (w_lfsr_en),
        .state   (R_y)
    );

    assign sample_ready = (r_state == IDLE);
    assign start        = w_accept;
    assign taps         = r_taps;
    assign sel_bits     = r_sel;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule : sc_fir_sequencer

`default_nettype wire
